// File: rtl/uart_pkg.sv
// Shared UART types and constants for the transmit serializer and future receive path.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam logic        UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uartTxState_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each serial bit.
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    output logic o_bit_end
);

    localparam int unsigned     CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_count;

    assign o_bit_end = (r_count == CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_count <= '0;
        end else if (i_clear || o_bit_end) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: frames each accepted byte as start, 8 data bits LSB first, optional even
// parity and 1 or 2 stop bits; back-to-back bytes are sent without idle bits.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_busy
);

    localparam logic [2:0] LAST_DATA = 3'(UART_DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    uartTxState_t              r_state, w_state_next;
    logic [2:0]                r_bit_cnt, w_bit_cnt_next;
    logic [UART_DATA_BITS-1:0] r_shift, w_shift_next;
    logic                      r_parity, w_parity_next;
    logic                      r_tx, w_tx_next;
    logic                      w_bit_end;
    logic                      w_last_stop;
    logic                      w_accept;
    logic                      w_clear;

    // Counter restarts on every state change so each state owns whole bit periods.
    assign w_clear = (w_state_next != r_state);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (w_clear),
        .o_bit_end(w_bit_end)
    );

    assign w_last_stop = (r_state == STOP) && w_bit_end && (r_bit_cnt == LAST_STOP);
    assign o_ready     = i_rst && ((r_state == IDLE) || w_last_stop);
    assign w_accept    = i_valid && o_ready;
    assign o_busy      = (r_state != IDLE);
    assign o_tx        = r_tx;

    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_shift_next   = r_shift;
        w_parity_next  = r_parity;

        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next  = START;
                    w_shift_next  = i_data;
                    w_parity_next = ^i_data;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_next   = DATA;
                    w_bit_cnt_next = 3'd0;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_shift_next = r_shift >> 1;
                    if (r_bit_cnt == LAST_DATA) begin
                        w_bit_cnt_next = 3'd0;
                        if (PARITY_EN != 0) begin
                            w_state_next = PARITY;
                        end else begin
                            w_state_next = STOP;
                        end
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_state_next   = STOP;
                    w_bit_cnt_next = 3'd0;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == LAST_STOP) begin
                        w_bit_cnt_next = 3'd0;
                        // Accepting here starts the next frame with no idle gap.
                        if (w_accept) begin
                            w_state_next  = START;
                            w_shift_next  = i_data;
                            w_parity_next = ^i_data;
                        end else begin
                            w_state_next = IDLE;
                        end
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 3'd1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        unique case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
            PARITY:  w_tx_next = w_parity_next;
            default: w_tx_next = UART_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state   <= IDLE;
            r_bit_cnt <= 3'd0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_tx      <= UART_IDLE_LEVEL;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_shift   <= w_shift_next;
            r_parity  <= w_parity_next;
            r_tx      <= w_tx_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: three configurations (8N1/CPB4, 8E1/CPB4, 8N2/CPB3) checked
// cycle by cycle against an expected line waveform built from the framing rules.
module tb_uart_tx_serializer;

    logic       clk;
    logic [2:0] rst;
    logic [2:0] valid;
    logic [2:0] tx;
    logic [2:0] busy;
    logic [2:0] ready;
    logic [7:0] data [3];

    int checks   = 0;
    int failures = 0;

    int cpb [3] = '{4, 4, 3};
    int par [3] = '{0, 1, 0};
    int stp [3] = '{1, 1, 2};

    logic [7:0] byte_q [$];

    uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1)) u_dut_8n1 (
        .i_clk(clk), .i_rst(rst[0]), .i_data(data[0]), .i_valid(valid[0]),
        .o_ready(ready[0]), .o_tx(tx[0]), .o_busy(busy[0])
    );

    uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(1)) u_dut_8e1 (
        .i_clk(clk), .i_rst(rst[1]), .i_data(data[1]), .i_valid(valid[1]),
        .o_ready(ready[1]), .o_tx(tx[1]), .o_busy(busy[1])
    );

    uart_tx_serializer #(.CLKS_PER_BIT(3), .PARITY_EN(0), .STOP_BITS(2)) u_dut_8n2 (
        .i_clk(clk), .i_rst(rst[2]), .i_data(data[2]), .i_valid(valid[2]),
        .o_ready(ready[2]), .o_tx(tx[2]), .o_busy(busy[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input int k, input string tag, input logic exp_ready);
        chk($sformatf("%s tx k%0d", tag, k), tx[k], 1'b1);
        chk($sformatf("%s busy k%0d", tag, k), busy[k], 1'b0);
        chk($sformatf("%s ready k%0d", tag, k), ready[k], exp_ready);
    endtask

    // Sends every byte in byte_q on instance k, holding valid while bytes remain, and checks
    // the line, busy and ready on every cycle from the accept edge to the first idle cycle.
    task automatic send(input int k, input string tag);
        bit etx [$];
        bit ebusy [$];
        bit erdy [$];
        bit fb [$];
        int n;
        int acc;
        bit pending;

        n = byte_q.size();
        for (int j = 0; j < n; j++) begin
            fb.delete();
            fb.push_back(1'b0);
            for (int i = 0; i < 8; i++) fb.push_back(byte_q[j][i]);
            if (par[k] != 0) fb.push_back(^byte_q[j]);
            for (int s = 0; s < stp[k]; s++) fb.push_back(1'b1);
            foreach (fb[b]) begin
                for (int r = 0; r < cpb[k]; r++) begin
                    etx.push_back(fb[b]);
                    ebusy.push_back(1'b1);
                    erdy.push_back(1'b0);
                end
            end
            erdy[erdy.size() - 1] = 1'b1;
        end
        etx.push_back(1'b1);
        ebusy.push_back(1'b0);
        erdy.push_back(1'b1);

        chk($sformatf("%s ready_pre k%0d", tag, k), ready[k], 1'b1);
        data[k]  = byte_q[0];
        valid[k] = 1'b1;
        pending  = 1'b1;
        acc      = 0;
        for (int c = 0; c < etx.size(); c++) begin
            @(negedge clk);
            if (pending) begin
                acc++;
                if (acc < n) begin
                    data[k]  = byte_q[acc];
                    valid[k] = 1'b1;
                end else begin
                    valid[k] = 1'b0;
                    data[k]  = 8'($urandom);
                end
            end
            chk($sformatf("%s tx k%0d c%0d", tag, k, c), tx[k], etx[c]);
            chk($sformatf("%s busy k%0d c%0d", tag, k, c), busy[k], ebusy[c]);
            chk($sformatf("%s ready k%0d c%0d", tag, k, c), ready[k], erdy[c]);
            pending = erdy[c] && valid[k];
        end
        byte_q.delete();
    endtask

    initial begin
        rst   = 3'b000;
        valid = 3'b000;
        for (int k = 0; k < 3; k++) data[k] = 8'h00;

        // Reset held for three cycles, then released.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) chk_idle(k, $sformatf("reset c%0d", c), 1'b0);
        end
        rst = 3'b111;
        #1;
        for (int k = 0; k < 3; k++) chk_idle(k, "release", 1'b1);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) chk_idle(k, "idle", 1'b1);

        byte_q = '{8'h55};
        send(0, "single55");
        byte_q = '{8'hA5, 8'h3C};
        send(0, "b2b");
        byte_q = '{8'h07};
        send(1, "par07");
        byte_q = '{8'h03};
        send(1, "par03");
        byte_q = '{8'hFF};
        send(2, "stop2ff");

        // Reset during data bit 3 of 0x00 (cycles 16..19 after accept).
        data[0]  = 8'h00;
        valid[0] = 1'b1;
        @(negedge clk);
        valid[0] = 1'b0;
        data[0]  = 8'($urandom);
        repeat (17) @(negedge clk);
        chk("midrst pre tx", tx[0], 1'b0);
        chk("midrst pre busy", busy[0], 1'b1);
        rst[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_idle(0, $sformatf("midrst c%0d", c), 1'b0);
        end
        rst[0] = 1'b1;
        #1;
        chk_idle(0, "midrst release", 1'b1);
        byte_q = '{8'h81};
        send(0, "after_rst81");

        // Random bursts on every configuration.
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 3; k++) begin
                int n;
                n = $urandom_range(1, 3);
                for (int j = 0; j < n; j++) byte_q.push_back(8'($urandom));
                send(k, $sformatf("rand%0d", r));
                repeat ($urandom_range(0, 2)) @(negedge clk);
                chk_idle(k, $sformatf("rand%0d gap", r), 1'b1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
